// File: rtl/ser_pkg.sv
// Purpose: shared types and constants for the word-to-bit serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ser_pkg;

    // Shifter FSM: IDLE drives the idle level, SHIFT emits one data bit per cycle.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Legal word lengths for the WIDTH parameter.
    localparam int SER_WIDTH_MIN = 2;
    localparam int SER_WIDTH_MAX = 32;

    // Width of the in-word bit counter for a given word length.
    function automatic int ser_cnt_bits(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/ser_hold_buf.sv
// Purpose: one-entry holding register for a word that arrives while the shifter is busy.
// Latency: word is visible on hold_dat the cycle after load_vld.
// Backpressure: owner stalls the producer when full and not draining; load wins over drain.
module ser_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             load_vld,
    input  logic [WIDTH-1:0] load_dat,
    input  logic             drain,
    output logic             full,
    output logic [WIDTH-1:0] hold_dat
);

    // Load has priority: a drain and a load on the same edge leave the new word held.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            full     <= 1'b0;
            hold_dat <= '0;
        end else if (load_vld) begin
            full     <= 1'b1;
            hold_dat <= load_dat;
        end else if (drain) begin
            full     <= 1'b0;
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// Purpose: parallel word to serial bit stream (X/X_Valid/Last); SER_HOLD_BUF_EN adds a one-entry holding buffer.
// Latency: first bit on X the cycle after the accept edge; a word occupies WIDTH consecutive cycles.
// Backpressure: In_Ready in IDLE and Last cycle (unbuffered) or while the buffer can take a word (buffered).
module bit_serializer #(
    parameter int WIDTH     = 8,     // word length, legal range 2..32
    parameter bit MSB_FIRST = 1'b1,  // 1: MSB leaves first, 0: LSB leaves first
    parameter bit IDLE_BIT  = 1'b0   // level on X when no bit is valid
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] Din,
    input  logic             In_Valid,
    output logic             In_Ready,
    output logic             X,
    output logic             X_Valid,
    output logic             Last
);
    import ser_pkg::*;

    localparam int            CW       = ser_cnt_bits(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    ser_state_t       state;
    ser_state_t       state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic [WIDTH-1:0] sreg_shifted;

    logic             rdy_en;      // low while in reset and until the first edge after release
    logic             last_bit;    // current X is the final bit of the word
    logic             accept;      // producer handshake completes on this edge
    logic             load_vld;    // a new word enters the shifter on this edge
    logic [WIDTH-1:0] load_dat;

    assign last_bit = (state == SHIFT) && (cnt == CNT_LAST);
    assign accept   = In_Valid && In_Ready;

    // The bit on X always sits at the outgoing end of the shift register.
    assign sreg_shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

`ifdef SER_HOLD_BUF_EN
    logic             buf_full;
    logic [WIDTH-1:0] buf_dat;
    logic             buf_drain;
    logic             buf_load;
    logic             direct;

    // The buffer empties into the shifter at the end of every Last cycle in
    // which it is full, so that cycle can also take a new word into the slot
    // being freed: ready counts a draining buffer as not full.
    assign buf_drain = last_bit && buf_full;
    assign In_Ready  = rdy_en && (!buf_full || last_bit);

    // Words go straight to the shifter when it is idle or finishing with nothing
    // queued; otherwise they wait in the buffer.
    assign direct    = accept && ((state == IDLE) || (last_bit && !buf_full));
    assign buf_load  = accept && !direct;
    assign load_vld  = direct || buf_drain;
    assign load_dat  = buf_drain ? buf_dat : Din;

    ser_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold_buf (
        .Clk      (Clk),
        .Rst      (Rst),
        .load_vld (buf_load),
        .load_dat (Din),
        .drain    (buf_drain),
        .full     (buf_full),
        .hold_dat (buf_dat)
    );
`else
    // Without a buffer the only free slots are idle and the final bit of a word.
    assign In_Ready = rdy_en && ((state == IDLE) || last_bit);
    assign load_vld = accept;
    assign load_dat = Din;
`endif

    // Ready enable: held low by reset, rises on the first edge after release.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    // FSM state, bit counter and shift register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sreg  <= sreg_nxt;
        end
    end

    // Next state and serial outputs; a word loaded in the Last cycle keeps the FSM in SHIFT.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sreg_nxt  = sreg;
        X         = IDLE_BIT;
        X_Valid   = 1'b0;
        Last      = 1'b0;

        case (state)
            IDLE: begin
                if (load_vld) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                    sreg_nxt  = load_dat;
                end
            end
            SHIFT: begin
                X       = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
                X_Valid = 1'b1;
                Last    = last_bit;
                if (last_bit) begin
                    // Counter wraps on every word boundary, whether or not a word follows.
                    cnt_nxt = '0;
                    if (load_vld) begin
                        sreg_nxt = load_dat;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt  = cnt + 1'b1;
                    sreg_nxt = sreg_shifted;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Purpose: self-checking bench for bit_serializer (MSB-first and LSB-first instances side by side).
// Latency: n/a.
// Backpressure: n/a.
module tb_bit_serializer;

    localparam int W = 8;
`ifdef SER_HOLD_BUF_EN
    localparam int OCC_LIMIT = W + 1;   // ready while current word plus held word fit after this edge
`else
    localparam int OCC_LIMIT = 1;       // ready only when idle or on the final bit
`endif

    logic         Clk      = 1'b0;
    logic         Rst      = 1'b1;
    logic [W-1:0] Din      = '0;
    logic         In_Valid = 1'b0;

    logic rdy_m, x_m, xv_m, last_m;
    logic rdy_l, x_l, xv_l, last_l;

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of bits still owed on X, front = bit due this cycle.
    bit q_m[$];
    bit q_l[$];
    bit rdy_ok = 1'b0;

    logic obs_x, obs_xl, obs_xv, obs_last, obs_rdy;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
        .Clk(Clk), .Rst(Rst), .Din(Din), .In_Valid(In_Valid),
        .In_Ready(rdy_m), .X(x_m), .X_Valid(xv_m), .Last(last_m)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .Clk(Clk), .Rst(Rst), .Din(Din), .In_Valid(In_Valid),
        .In_Ready(rdy_l), .X(x_l), .X_Valid(xv_l), .Last(last_l)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // One clock cycle: drive, check both instances against the model at negedge, advance the model.
    task automatic cycle(input logic v, input logic [W-1:0] d);
        bit er, ev_m, ex_m, el_m, ev_l, ex_l, el_l, acc;
        In_Valid = v;
        Din      = d;
        @(negedge Clk);
        er   = rdy_ok && (q_m.size() <= OCC_LIMIT);
        ev_m = q_m.size() > 0;
        ex_m = ev_m ? q_m[0] : 1'b0;
        el_m = ev_m && (((q_m.size() - 1) % W) == 0);
        ev_l = q_l.size() > 0;
        ex_l = ev_l ? q_l[0] : 1'b0;
        el_l = ev_l && (((q_l.size() - 1) % W) == 0);
        checks++; if (rdy_m !== er)   begin failures++; $display("FAIL model_ready_msb t=%0t got=%b exp=%b", $time, rdy_m, er); end
        checks++; if (rdy_l !== er)   begin failures++; $display("FAIL model_ready_lsb t=%0t got=%b exp=%b", $time, rdy_l, er); end
        checks++; if (xv_m !== ev_m)  begin failures++; $display("FAIL model_xvalid_msb t=%0t got=%b exp=%b", $time, xv_m, ev_m); end
        checks++; if (xv_l !== ev_l)  begin failures++; $display("FAIL model_xvalid_lsb t=%0t got=%b exp=%b", $time, xv_l, ev_l); end
        checks++; if (x_m !== ex_m)   begin failures++; $display("FAIL model_x_msb t=%0t got=%b exp=%b", $time, x_m, ex_m); end
        checks++; if (x_l !== ex_l)   begin failures++; $display("FAIL model_x_lsb t=%0t got=%b exp=%b", $time, x_l, ex_l); end
        checks++; if (last_m !== el_m) begin failures++; $display("FAIL model_last_msb t=%0t got=%b exp=%b", $time, last_m, el_m); end
        checks++; if (last_l !== el_l) begin failures++; $display("FAIL model_last_lsb t=%0t got=%b exp=%b", $time, last_l, el_l); end
        obs_x    = x_m;
        obs_xl   = x_l;
        obs_xv   = xv_m;
        obs_last = last_m;
        obs_rdy  = rdy_m;
        acc = v && er;
        @(posedge Clk);
        if (q_m.size() > 0) void'(q_m.pop_front());
        if (q_l.size() > 0) void'(q_l.pop_front());
        if (acc) begin
            for (int i = 0; i < W; i++) begin
                q_m.push_back(d[W-1-i]);
                q_l.push_back(d[i]);
            end
        end
        rdy_ok = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge Clk);
        checks++; if (rdy_m !== 1'b0)  begin failures++; $display("FAIL reset_ready got=%b exp=0", rdy_m); end
        checks++; if (xv_m !== 1'b0)   begin failures++; $display("FAIL reset_xvalid got=%b exp=0", xv_m); end
        checks++; if (x_m !== 1'b0)    begin failures++; $display("FAIL reset_x got=%b exp=0", x_m); end
        checks++; if (last_m !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", last_m); end
        checks++; if (rdy_l !== 1'b0)  begin failures++; $display("FAIL reset_ready_lsb got=%b exp=0", rdy_l); end
        checks++; if (xv_l !== 1'b0)   begin failures++; $display("FAIL reset_xvalid_lsb got=%b exp=0", xv_l); end
        @(posedge Clk); #1;
        Rst = 1'b0;
        rdy_ok = 1'b0;
        q_m.delete();
        q_l.delete();
        cycle(1'b0, '0);
        checks++; if (obs_rdy !== 1'b0) begin failures++; $display("FAIL release_ready_before_edge got=%b exp=0", obs_rdy); end
        cycle(1'b0, '0);
        checks++; if (obs_rdy !== 1'b1) begin failures++; $display("FAIL release_ready_after_edge got=%b exp=1", obs_rdy); end
    endtask

    task automatic test_bit_order;
        logic [W-1:0] sm, sl, lm;
        sm = '0; sl = '0; lm = '0;
        cycle(1'b1, 8'hA5);
        for (int c = 1; c <= 8; c++) begin
            cycle(1'b0, '0);
            sm = {sm[W-2:0], obs_x};
            sl = {sl[W-2:0], obs_xl};
            lm = {lm[W-2:0], obs_last};
        end
        checks++; if (sm !== 8'hA5) begin failures++; $display("FAIL a5_msb_stream got=%h exp=a5", sm); end
        checks++; if (sl !== 8'hA5) begin failures++; $display("FAIL a5_lsb_stream got=%h exp=a5", sl); end
        checks++; if (lm !== 8'h01) begin failures++; $display("FAIL a5_last_position got=%b exp=00000001", lm); end
        cycle(1'b0, '0);
        checks++; if (obs_xv !== 1'b0) begin failures++; $display("FAIL a5_cycle9_xvalid got=%b exp=0", obs_xv); end
        checks++; if (obs_x !== 1'b0)  begin failures++; $display("FAIL a5_cycle9_x got=%b exp=0", obs_x); end
        cycle(1'b1, 8'h01);
        for (int c = 1; c <= 8; c++) begin
            cycle(1'b0, '0);
            sm = {sm[W-2:0], obs_x};
            sl = {sl[W-2:0], obs_xl};
        end
        checks++; if (sm !== 8'h01) begin failures++; $display("FAIL w01_msb_stream got=%h exp=01", sm); end
        checks++; if (sl !== 8'h80) begin failures++; $display("FAIL w01_lsb_stream got=%h exp=80", sl); end
        cycle(1'b0, '0);
    endtask

`ifdef SER_HOLD_BUF_EN
    task automatic test_back_to_back;
        logic [24:0] rdy_seen;
        logic [23:0] bits;
        int vcount;
        logic v;
        logic [W-1:0] d;
        rdy_seen = '0; bits = '0; vcount = 0;
        cycle(1'b1, 8'hF0);
        rdy_seen[0] = obs_rdy;
        for (int c = 1; c <= 24; c++) begin
            if (c == 1)      begin v = 1'b1; d = 8'h0F; end
            else if (c <= 8) begin v = 1'b1; d = 8'hAA; end
            else             begin v = 1'b0; d = '0;    end
            cycle(v, d);
            rdy_seen[c] = obs_rdy;
            bits = {bits[22:0], obs_x};
            vcount += int'(obs_xv);
        end
        checks++; if (bits !== 24'hF00FAA) begin failures++; $display("FAIL buf_stream got=%h exp=f00faa", bits); end
        checks++; if (vcount != 24) begin failures++; $display("FAIL buf_contiguous got=%0d exp=24", vcount); end
        checks++; if (rdy_seen[8:0] !== 9'b1_0000_0011) begin failures++; $display("FAIL buf_ready_pattern got=%b exp=100000011", rdy_seen[8:0]); end
        cycle(1'b0, '0);
        checks++; if (obs_xv !== 1'b0) begin failures++; $display("FAIL buf_end_xvalid got=%b exp=0", obs_xv); end
    endtask
`else
    task automatic test_back_to_back;
        logic [16:0] rdy_seen;
        logic [15:0] bits;
        int vcount;
        rdy_seen = '0; bits = '0; vcount = 0;
        cycle(1'b1, 8'hA5);
        rdy_seen[0] = obs_rdy;
        for (int c = 1; c <= 16; c++) begin
            cycle((c <= 8) ? 1'b1 : 1'b0, 8'h3C);
            rdy_seen[c] = obs_rdy;
            bits = {bits[14:0], obs_x};
            vcount += int'(obs_xv);
        end
        checks++; if (bits !== 16'hA53C) begin failures++; $display("FAIL b2b_stream got=%h exp=a53c", bits); end
        checks++; if (vcount != 16) begin failures++; $display("FAIL b2b_contiguous got=%0d exp=16", vcount); end
        checks++; if (rdy_seen[15:0] !== 16'h0101) begin failures++; $display("FAIL b2b_ready_pattern got=%b exp=0000000100000001", rdy_seen[15:0]); end
        cycle(1'b0, '0);
        checks++; if (obs_xv !== 1'b0) begin failures++; $display("FAIL b2b_end_xvalid got=%b exp=0", obs_xv); end
    endtask
`endif

    task automatic test_reset_mid_word;
        int vseen;
        cycle(1'b1, 8'hFF);
        cycle(1'b0, '0);
        cycle(1'b0, '0);
        // now inside bit cycle 3 of the word
        Rst = 1'b1;
        #1;
        checks++; if (x_m !== 1'b0)    begin failures++; $display("FAIL midrst_x got=%b exp=0", x_m); end
        checks++; if (xv_m !== 1'b0)   begin failures++; $display("FAIL midrst_xvalid got=%b exp=0", xv_m); end
        checks++; if (rdy_m !== 1'b0)  begin failures++; $display("FAIL midrst_ready got=%b exp=0", rdy_m); end
        checks++; if (last_m !== 1'b0) begin failures++; $display("FAIL midrst_last got=%b exp=0", last_m); end
        checks++; if (xv_l !== 1'b0)   begin failures++; $display("FAIL midrst_xvalid_lsb got=%b exp=0", xv_l); end
        q_m.delete();
        q_l.delete();
        rdy_ok = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        checks++; if (xv_m !== 1'b0) begin failures++; $display("FAIL midrst_hold_xvalid got=%b exp=0", xv_m); end
        Rst = 1'b0;
        vseen = 0;
        for (int c = 0; c < 12; c++) begin
            cycle(1'b0, '0);
            vseen += int'(obs_xv);
            if (c == 1) begin
                checks++; if (obs_rdy !== 1'b1) begin failures++; $display("FAIL midrst_ready_after_release got=%b exp=1", obs_rdy); end
            end
        end
        checks++; if (vseen != 0) begin failures++; $display("FAIL midrst_residual_bits got=%0d exp=0", vseen); end
    endtask

    task automatic test_detector;
        logic [W-1:0] sm;
        logic [2:0]   h;
        logic [8:1]   ym, ey;
        sm = '0; h = '0; ym = '0; ey = '0;
        ey[3] = 1'b1;
        ey[6] = 1'b1;
        cycle(1'b1, 8'h90);
        for (int c = 1; c <= 8; c++) begin
            cycle(1'b0, '0);
            sm = {sm[W-2:0], obs_x};
            h  = {h[1:0], obs_x};
            ym[c] = obs_xv && (h == 3'b100);
        end
        checks++; if (sm !== 8'h90) begin failures++; $display("FAIL det_stream got=%h exp=90", sm); end
        checks++; if (ym !== ey)    begin failures++; $display("FAIL det_y_cycles got=%b exp=%b", ym, ey); end
        cycle(1'b0, '0);
    endtask

    task automatic test_random;
        logic [W-1:0] d;
        logic v;
        for (int n = 0; n < 400; n++) begin
            v = ($urandom_range(0, 3) != 0);
            d = W'($urandom);
            cycle(v, d);
        end
        repeat (2 * W + 4) cycle(1'b0, '0);
    endtask

    initial begin
        test_reset();
        test_bit_order();
        test_back_to_back();
        test_reset_mid_word();
        test_detector();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
